alu_chrom_stim_gen: RTL and testbench

Hardware stimulus generator driven by one genetic-algorithm chromosome. It sits directly downstream of the GA test parameter set and directly upstream of the ALU input driver. Software loads the chromosome's per-field value ranges through a configuration port. After START, the block emits a fixed number of ALU transactions, each with its own inter-transaction delay, over a valid/ready handshake.

---
 rtl/alu_chrom_stim_gen.sv | 204 ++++++++++++++++++++
 tb/tb_alu_chrom_stim_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_chrom_stim_gen.sv
// alu_chrom_stim_gen: ALU transaction generator driven by one GA chromosome.
// Per-field value ranges are loaded through the CFG port. After START the
// block emits TRANS_COUNT transactions over a valid/ready handshake, each
// preceded by a drawn inter-transaction delay.
// Optional feature: define ALU_STIM_STALL_CNT_EN to enable the STALL_CNT counter.
module alu_chrom_stim_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_RANGES  = 10,
  parameter int unsigned TRANS_COUNT = 100,
  parameter int unsigned DELAY_MAX   = 10,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  CFG_WE,
  input  logic [1:0]            CFG_FIELD,
  input  logic [3:0]            CFG_IDX,
  input  logic                  CFG_LAST,
  input  logic [DATA_WIDTH-1:0] CFG_LO,
  input  logic [DATA_WIDTH-1:0] CFG_HI,
  output logic                  CFG_ERR,
  output logic                  OUT_VLD,
  input  logic                  OUT_RDY,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  output logic [3:0]            OPCODE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           STALL_CNT
);

  localparam int unsigned SLOTS  = 16;
  localparam int unsigned PW     = 2 * DATA_WIDTH + 1;
  localparam int unsigned TCW    = $clog2(TRANS_COUNT + 1);
  localparam int unsigned ONES_I = (2 ** DATA_WIDTH) - 1;
  localparam int unsigned DMAX_I = (DELAY_MAX > ONES_I) ? ONES_I : DELAY_MAX;
  localparam logic [DATA_WIDTH-1:0] DMAX = DATA_WIDTH'(DMAX_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_DELAY,
    S_SEND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] lo_mem [3][SLOTS];
  logic [DATA_WIDTH-1:0] hi_mem [3][SLOTS];
  logic [4:0]            cnt_mem [3];

  logic [15:0]           lfsr_q, lfsr_next;
  logic [1:0]            phase_q;
  logic [DATA_WIDTH-1:0] dly_q;
  logic [TCW-1:0]        trans_q;

  logic                  cfg_open, cfg_bad, cfg_acc, start_acc, last_trans;
  logic [DATA_WIDTH-1:0] wr_lo, wr_hi;

  logic [1:0]            draw_field;
  logic [4:0]            draw_cnt;
  logic [3:0]            draw_slot;
  logic [DATA_WIDTH-1:0] sel_lo, sel_hi, r_lo_m, draw_val;
  logic [DATA_WIDTH:0]   span;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Configuration acceptance, rejection and delay-field clipping
  always_comb begin
    cfg_open   = (state_q == S_IDLE) || (state_q == S_DONE);
    cfg_bad    = (CFG_FIELD == 2'd3) || (32'(CFG_IDX) >= MAX_RANGES) || (CFG_LO > CFG_HI);
    cfg_acc    = cfg_open && CFG_WE && !cfg_bad;
    start_acc  = cfg_open && START;
    last_trans = (trans_q == TCW'(TRANS_COUNT - 1));
    wr_lo      = CFG_LO;
    wr_hi      = CFG_HI;
    if (CFG_FIELD == 2'd0) begin
      wr_lo = (CFG_LO > DMAX) ? DMAX : CFG_LO;
      wr_hi = (CFG_HI > DMAX) ? DMAX : CFG_HI;
    end
  end

  // Range draw for the field selected by the current GEN phase, using post-step LFSR bits
  always_comb begin
    draw_field = (phase_q == 2'd3) ? 2'd0 : phase_q;
    draw_cnt   = cnt_mem[draw_field];
    draw_slot  = 4'(({5'd0, lfsr_next[15:8]} * {8'd0, draw_cnt}) >> 8);
    sel_lo     = lo_mem[draw_field][draw_slot];
    sel_hi     = hi_mem[draw_field][draw_slot];
    r_lo_m     = lfsr_next[DATA_WIDTH-1:0];
    span       = {1'b0, sel_hi} - {1'b0, sel_lo} + (DATA_WIDTH + 1)'(1);
    draw_val   = sel_lo + DATA_WIDTH'((PW'(r_lo_m) * PW'(span)) >> DATA_WIDTH);
  end

  // Range table storage and the registered reject pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned f = 0; f < 3; f++) begin
        cnt_mem[2'(f)] <= 5'd1;
        for (int unsigned s = 0; s < SLOTS; s++) begin
          lo_mem[2'(f)][4'(s)] <= '0;
          hi_mem[2'(f)][4'(s)] <= (s == 0) ? ((f == 0) ? DMAX : '1) : '0;
        end
      end
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= cfg_open && CFG_WE && cfg_bad;
      if (cfg_acc) begin
        lo_mem[CFG_FIELD][CFG_IDX] <= wr_lo;
        hi_mem[CFG_FIELD][CFG_IDX] <= wr_hi;
        if (CFG_LAST) cnt_mem[CFG_FIELD] <= 5'(CFG_IDX) + 5'd1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state and status outputs
  always_comb begin
    state_d = state_q;
    OUT_VLD = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      S_IDLE:  if (START) state_d = S_GEN;
      S_GEN: begin
        BUSY = 1'b1;
        if (phase_q == 2'd3) state_d = (dly_q == '0) ? S_SEND : S_DELAY;
      end
      S_DELAY: begin
        BUSY = 1'b1;
        if (dly_q == DATA_WIDTH'(1)) state_d = S_SEND;
      end
      S_SEND: begin
        BUSY    = 1'b1;
        OUT_VLD = 1'b1;
        if (OUT_RDY) state_d = last_trans ? S_DONE : S_GEN;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (START) state_d = S_GEN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Generation datapath: LFSR stepping, draws, delay countdown, transaction count
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q  <= SEED;
      phase_q <= '0;
      dly_q   <= '0;
      trans_q <= '0;
      OP_A    <= '0;
      OP_B    <= '0;
      OPCODE  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            trans_q <= '0;
            phase_q <= '0;
          end
        end
        S_GEN: begin
          lfsr_q  <= lfsr_next;
          phase_q <= phase_q + 2'd1;
          case (phase_q)
            2'd0:    dly_q  <= draw_val;
            2'd1:    OP_A   <= draw_val;
            2'd2:    OP_B   <= draw_val;
            default: OPCODE <= lfsr_next[3:0];
          endcase
        end
        S_DELAY: dly_q <= dly_q - DATA_WIDTH'(1);
        S_SEND:  if (OUT_RDY) trans_q <= trans_q + TCW'(1);
        default: ;
      endcase
    end
  end

`ifdef ALU_STIM_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles offered but not accepted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                              stall_q <= '0;
    else if (start_acc)                                    stall_q <= '0;
    else if (state_q == S_SEND && !OUT_RDY && stall_q != '1) stall_q <= stall_q + 16'd1;
  end

  assign STALL_CNT = stall_q;
`else
  assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_alu_chrom_stim_gen.sv
// Testbench for alu_chrom_stim_gen: randomized configuration and backpressure,
// checked against a transaction-level reference model of the range draws.
module tb_alu_chrom_stim_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned MR = 10;
  localparam int unsigned TC = 100;
  localparam int unsigned DM = 10;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          CFG_WE = 1'b0;
  logic [1:0]    CFG_FIELD = '0;
  logic [3:0]    CFG_IDX = '0;
  logic          CFG_LAST = 1'b0;
  logic [DW-1:0] CFG_LO = '0;
  logic [DW-1:0] CFG_HI = '0;
  logic          CFG_ERR;
  logic          OUT_VLD;
  logic          OUT_RDY = 1'b1;
  logic [DW-1:0] OP_A, OP_B;
  logic [3:0]    OPCODE;
  logic          BUSY, DONE;
  logic [15:0]   STALL_CNT;

  alu_chrom_stim_gen #(
    .DATA_WIDTH (DW),
    .MAX_RANGES (MR),
    .TRANS_COUNT(TC),
    .DELAY_MAX  (DM),
    .SEED       (SEED_V)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .CFG_WE   (CFG_WE),
    .CFG_FIELD(CFG_FIELD),
    .CFG_IDX  (CFG_IDX),
    .CFG_LAST (CFG_LAST),
    .CFG_LO   (CFG_LO),
    .CFG_HI   (CFG_HI),
    .CFG_ERR  (CFG_ERR),
    .OUT_VLD  (OUT_VLD),
    .OUT_RDY  (OUT_RDY),
    .OP_A     (OP_A),
    .OP_B     (OP_B),
    .OPCODE   (OPCODE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned err_pulses = 0;
  int unsigned obs_a[$];
  int unsigned obs_b[$];
  int unsigned obs_lat[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: range tables and LFSR
  int unsigned m_lo [3][16];
  int unsigned m_hi [3][16];
  int unsigned m_cnt [3];
  logic [15:0] m_lfsr;

  function automatic void m_reset();
    for (int f = 0; f < 3; f++) begin
      m_cnt[f] = 1;
      for (int s = 0; s < 16; s++) begin
        m_lo[f][s] = 0;
        m_hi[f][s] = 0;
      end
    end
    m_hi[0][0] = DM;
    m_hi[1][0] = (1 << DW) - 1;
    m_hi[2][0] = (1 << DW) - 1;
    m_lfsr = SEED_V;
  endfunction

  function automatic void m_step();
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int unsigned m_draw(input int unsigned f);
    int unsigned rh, rl, ix, span;
    m_step();
    rh   = int'(m_lfsr) >> 8;
    rl   = int'(m_lfsr) & ((1 << DW) - 1);
    ix   = (rh * m_cnt[f]) >> 8;
    span = m_hi[f][ix] - m_lo[f][ix] + 1;
    return m_lo[f][ix] + ((rl * span) >> DW);
  endfunction

  function automatic bit m_cfg(input int unsigned f, input int unsigned idx, input int unsigned last,
                               input int unsigned lo, input int unsigned hi);
    if (f == 3 || idx >= MR || lo > hi) return 1'b1;
    if (f == 0) begin
      if (lo > DM) lo = DM;
      if (hi > DM) hi = DM;
    end
    m_lo[f][idx] = lo;
    m_hi[f][idx] = hi;
    if (last != 0) m_cnt[f] = idx + 1;
    return 1'b0;
  endfunction

  task automatic cfg_wr(input int unsigned f, input int unsigned idx, input int unsigned last,
                        input int unsigned lo, input int unsigned hi);
    bit exp_err;
    exp_err = m_cfg(f, idx, last, lo, hi);
    @(negedge CLK);
    CFG_WE    = 1'b1;
    CFG_FIELD = 2'(f);
    CFG_IDX   = 4'(idx);
    CFG_LAST  = (last != 0);
    CFG_LO    = DW'(lo);
    CFG_HI    = DW'(hi);
    @(negedge CLK);
    CFG_WE = 1'b0;
    chk("cfg_err", CFG_ERR, exp_err);
    if (CFG_ERR === 1'b1) err_pulses++;
    @(negedge CLK);
    chk("cfg_err_clr", CFG_ERR, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, OUT_VLD, 0);
    chk({tag, "_a"}, OP_A, 0);
    chk({tag, "_b"}, OP_B, 0);
    chk({tag, "_op"}, OPCODE, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_stall"}, STALL_CNT, 0);
    chk({tag, "_err"}, CFG_ERR, 0);
  endtask

  // mode 0: always ready; 1: 20-cycle stall on transaction 3; 2: random 0..3 stalls.
  // abort_at >= 0 asserts reset in the first DELAY cycle of that transaction.
  task automatic run_chrom(input int mode, input int abort_at);
    int unsigned d, a, b, op, k, s, stall_exp;
    stall_exp = 0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int t = 0; t < TC; t++) begin
      d = m_draw(0);
      a = m_draw(1);
      b = m_draw(2);
      m_step();
      op = int'(m_lfsr) & 15;
      if (t == abort_at) begin
        repeat (4) @(negedge CLK);
        chk("abort_busy", BUSY, 1);
        chk("abort_vld", OUT_VLD, 0);
        #2 RST = 1'b0;
        #1 chk_zero("abort");
        return;
      end
      k = 1;
      while (OUT_VLD !== 1'b1 && k < 64) begin
        @(negedge CLK);
        k++;
      end
      if (OUT_VLD !== 1'b1) begin
        chk("vld_timeout", OUT_VLD, 1);
        return;
      end
      chk("latency", k, 5 + d);
      chk("delay_le_max", (k <= 5 + DM), 1);
      chk("op_a", OP_A, a);
      chk("op_b", OP_B, b);
      chk("opcode", OPCODE, op);
      chk("busy_send", BUSY, 1);
      obs_a.push_back(int'(OP_A));
      obs_b.push_back(int'(OP_B));
      obs_lat.push_back(k);
      if (mode == 1) s = (t == 3) ? 20 : 0;
      else if (mode == 2) s = $urandom_range(0, 3);
      else s = 0;
      if (s > 0) begin
        OUT_RDY = 1'b0;
        for (int unsigned i = 0; i < s; i++) begin
          @(negedge CLK);
          chk("hold_vld", OUT_VLD, 1);
          chk("hold_a", OP_A, a);
          chk("hold_b", OP_B, b);
          chk("hold_op", OPCODE, op);
        end
        OUT_RDY = 1'b1;
      end
      stall_exp += s;
      @(negedge CLK);
      chk("vld_fall", OUT_VLD, 0);
    end
    chk("done", DONE, 1);
    chk("busy_end", BUSY, 0);
`ifdef ALU_STIM_STALL_CNT_EN
    chk("stall_cnt", STALL_CNT, stall_exp);
`else
    chk("stall_cnt", STALL_CNT, 0);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_t;
    int unsigned n_bad, hit0, hit1, c, lo, hi, d;

    m_reset();
    repeat (3) @(negedge CLK);
    chk_zero("rst_held");
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("rst_rel");

    // Reset defaults, then a restart from DONE with one long stall
    run_chrom(0, -1);
    run_chrom(1, -1);

    // Rejected writes leave the model and DUT configuration untouched
    err_pulses = 0;
    cfg_wr(1, 0, 1, 9, 3);
    cfg_wr(1, 10, 1, 1, 2);
    cfg_wr(3, 0, 1, 0, 0);
    chk("reject_pulses", err_pulses, 3);
    run_chrom(0, -1);

    // Fixed single-value ranges and zero delay
    cfg_wr(1, 0, 1, 5, 5);
    cfg_wr(2, 0, 1, 200, 200);
    cfg_wr(0, 0, 1, 0, 0);
    obs_a.delete(); obs_b.delete(); obs_lat.delete();
    run_chrom(0, -1);
    n_bad = 0;
    foreach (obs_a[i]) if (obs_a[i] != 5 || obs_b[i] != 200 || obs_lat[i] != 5) n_bad++;
    chk("fixed_bad", n_bad, 0);
    chk("fixed_n", obs_a.size(), TC);

    // Two disjoint ranges for operand A
    cfg_wr(1, 0, 0, 0, 3);
    cfg_wr(1, 1, 1, 250, 255);
    obs_a.delete();
    run_chrom(0, -1);
    n_bad = 0; hit0 = 0; hit1 = 0;
    foreach (obs_a[i]) begin
      if (obs_a[i] <= 3) hit0++;
      else if (obs_a[i] >= 250) hit1++;
      else n_bad++;
    end
    chk("multi_bad", n_bad, 0);
    chk("multi_hit0", (hit0 > 0), 1);
    chk("multi_hit1", (hit1 > 0), 1);

    // Random configurations with random backpressure
    repeat (2) begin
      for (int unsigned f = 0; f < 3; f++) begin
        c = $urandom_range(1, MR);
        for (int unsigned i = 0; i < c; i++) begin
          lo = (f == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
          hi = (f == 0) ? $urandom_range(lo, 15) : $urandom_range(lo, 255);
          cfg_wr(f, i, (i == c - 1), lo, hi);
        end
      end
      lo = $urandom_range(0, 255);
      hi = $urandom_range(0, 255);
      cfg_wr(2, $urandom_range(0, 15), 0, lo, hi);
      run_chrom(2, -1);
    end

    // Reset mid-run in the DELAY of transaction 37 (or the next one with a delay)
    RST = 1'b0;
    m_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    abort_t = -1;
    for (int t = 0; t < TC; t++) begin
      d = m_draw(0);
      void'(m_draw(1));
      void'(m_draw(2));
      m_step();
      if (abort_t < 0 && t >= 36 && d > 0) abort_t = t;
    end
    m_reset();
    run_chrom(0, abort_t);
    repeat (2) @(negedge CLK);
    chk_zero("rst_hold2");
    RST = 1'b1;
    m_reset();
    @(negedge CLK);
    run_chrom(0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
